// File: rtl/muldiv_sched.sv
// Sequencer between EXE and the shared multiply/divide units: one request in flight,
// a single begin pulse, end-strobe or timeout capture, and a held result until acked.
module muldiv_sched #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    input  logic [31:0] op_src1,
    input  logic [31:0] op_src2,
    output logic        op_ready,
    input  logic        op_cancel,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_err,
    input  logic        res_ack,
    output logic        mult_begin,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    input  logic        mult_end,
    input  logic [63:0] product,
    output logic        div_begin,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic        div_end,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

    localparam logic [1:0]       OP_MULT  = 2'b01;
    localparam logic [1:0]       OP_DIV   = 2'b10;
    // The increment out of this value is the one that reaches TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [1:0]       type_q;
    logic [31:0]      op1_q;
    logic [31:0]      op2_q;
    logic [CNT_W-1:0] cnt;

    logic        is_mult;
    logic        end_hit;
    logic        expired;
    logic        accept;
    logic        div_zero;
    logic [31:0] unit_hi;
    logic [31:0] unit_lo;

    assign is_mult  = (type_q == OP_MULT);
    assign end_hit  = is_mult ? mult_end : div_end;
    assign expired  = (cnt == CNT_LAST);
    assign accept   = op_valid && !op_cancel && (op_type != 2'b00);
    assign div_zero = (op_type != OP_MULT) && (op_src2 == 32'd0);
    assign unit_hi  = is_mult ? product[63:32] : ((type_q == OP_DIV) ? quotient : remainder);
    assign unit_lo  = is_mult ? product[31:0] : remainder;

    assign op_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign mult_op1 = op1_q;
    assign mult_op2 = op2_q;
    assign div_op1  = op1_q;
    assign div_op2  = op2_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            type_q     <= 2'b00;
            op1_q      <= 32'd0;
            op2_q      <= 32'd0;
            cnt        <= '0;
            res_valid  <= 1'b0;
            res_err    <= 1'b0;
            res_hi     <= 32'd0;
            res_lo     <= 32'd0;
            mult_begin <= 1'b0;
            div_begin  <= 1'b0;
        end else begin
            mult_begin <= 1'b0;
            div_begin  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        type_q <= op_type;
                        op1_q  <= op_src1;
                        op2_q  <= op_src2;
                        if (div_zero) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                            res_err   <= 1'b0;
                            res_hi    <= (op_type == OP_DIV) ? 32'hFFFF_FFFF : op_src1;
                            res_lo    <= op_src1;
                        end else begin
                            state      <= ISSUE;
                            mult_begin <= (op_type == OP_MULT);
                            div_begin  <= (op_type != OP_MULT);
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= op_cancel ? DRAIN : WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (op_cancel) begin
                        // A unit that has already finished or given up leaves nothing to drain.
                        state <= (end_hit || expired) ? IDLE : DRAIN;
                    end else if (end_hit) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_err   <= 1'b0;
                        res_hi    <= unit_hi;
                        res_lo    <= unit_lo;
                    end else if (expired) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_hi    <= 32'd0;
                        res_lo    <= 32'd0;
                    end
                end
                DONE: begin
                    if (res_ack || op_cancel) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (end_hit || expired) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized scoreboard bench for muldiv_sched with behavioural multiply/divide unit stubs.
module tb_muldiv_sched;

    localparam int         TO   = 8;
    localparam logic [1:0] MULT = 2'b01;
    localparam logic [1:0] DIV  = 2'b10;
    localparam logic [1:0] MOD  = 2'b11;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_type = 2'b00;
    logic [31:0] op_src1 = 32'd0;
    logic [31:0] op_src2 = 32'd0;
    logic        op_ready;
    logic        op_cancel = 1'b0;
    logic        res_valid;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_err;
    logic        res_ack = 1'b0;
    logic        mult_begin;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic        mult_end = 1'b0;
    logic [63:0] product = 64'd0;
    logic        div_begin;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_end = 1'b0;
    logic [31:0] quotient = 32'd0;
    logic [31:0] remainder = 32'd0;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int stub_dly = 1;
    int mb_cnt   = 0;
    int db_cnt   = 0;
    logic [64:0] exp_q[$];

    muldiv_sched #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_type(op_type), .op_src1(op_src1), .op_src2(op_src2),
        .op_ready(op_ready), .op_cancel(op_cancel),
        .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo), .res_err(res_err),
        .res_ack(res_ack),
        .mult_begin(mult_begin), .mult_op1(mult_op1), .mult_op2(mult_op2),
        .mult_end(mult_end), .product(product),
        .div_begin(div_begin), .div_op1(div_op1), .div_op2(div_op2),
        .div_end(div_end), .quotient(quotient), .remainder(remainder),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    // Begin pulses counted as high cycles, so a stretched pulse shows up as an extra count.
    initial forever begin
        @(negedge clk);
        if (mult_begin) mb_cnt++;
        if (div_begin) db_cnt++;
    end

    // Unit stubs: end strobe stub_dly cycles after the begin cycle; 0 means the unit hangs.
    initial begin : mult_stub
        int d;
        forever begin
            @(negedge clk);
            if (mult_begin) begin
                d = stub_dly;
                if (d > 0) begin
                    repeat (d) @(negedge clk);
                    product  = {32'd0, mult_op1} * {32'd0, mult_op2};
                    mult_end = 1'b1;
                    @(negedge clk);
                    mult_end = 1'b0;
                end
            end
        end
    end

    initial begin : div_stub
        int d;
        forever begin
            @(negedge clk);
            if (div_begin) begin
                d = stub_dly;
                if (d > 0) begin
                    repeat (d) @(negedge clk);
                    quotient  = (div_op2 == 0) ? 32'hFFFF_FFFF : div_op1 / div_op2;
                    remainder = (div_op2 == 0) ? div_op1 : div_op1 % div_op2;
                    div_end   = 1'b1;
                    @(negedge clk);
                    div_end = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        logic        prev;
        logic [64:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (res_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got %h, required no result", {res_hi, res_lo, res_err});
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {res_hi, res_lo, res_err}, e);
                end
            end
            prev = res_valid;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) chk("ready_wait", 65'(op_ready), 65'(1));
    endtask

    task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                          input int dly, input int ack_wait, input bit cancel_done);
        logic [31:0] eh, el;
        logic        ee;
        logic [63:0] p;
        int          lat, n, mb0, db0, exp_mb, exp_db;
        exp_mb = 0;
        exp_db = 0;
        if (t != MULT && b == 0) begin
            eh = (t == DIV) ? 32'hFFFF_FFFF : a;
            el = a;
            ee = 1'b0;
            lat = 1;
        end else begin
            exp_mb = (t == MULT) ? 1 : 0;
            exp_db = (t == MULT) ? 0 : 1;
            if (dly == 0) begin
                eh = 32'd0; el = 32'd0; ee = 1'b1; lat = TO + 2;
            end else begin
                ee = 1'b0;
                lat = 2 + dly;
                case (t)
                    MULT: begin p = 64'(a) * 64'(b); eh = p[63:32]; el = p[31:0]; end
                    DIV:  begin eh = a / b; el = a % b; end
                    default: begin eh = a % b; el = a % b; end
                endcase
            end
        end
        wait_ready();
        mb0 = mb_cnt;
        db0 = db_cnt;
        stub_dly = dly;
        op_valid = 1'b1; op_type = t; op_src1 = a; op_src2 = b;
        exp_q.push_back({eh, el, ee});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                op_valid = 1'b0;
                op_type  = 2'($urandom);
                op_src1  = $urandom;
                op_src2  = $urandom;
                chk("operands", 65'({mult_op1, mult_op2, div_op1 ^ div_op2}), 65'({a, b, a ^ b}));
            end
        end while (!res_valid && n < 40);
        chk("latency", 65'(n), 65'(lat));
        repeat (ack_wait) @(negedge clk);
        chk("done_hold", 65'({op_ready, res_valid}), 65'(2'b01));
        if (cancel_done) op_cancel = 1'b1;
        else res_ack = 1'b1;
        @(negedge clk);
        op_cancel = 1'b0;
        res_ack   = 1'b0;
        chk("after_ack", 65'({op_ready, busy, res_valid, res_err}), 65'(4'b1000));
        chk("begin_pulses", 65'({32'(mb_cnt - mb0), 32'(db_cnt - db0)}), 65'({32'(exp_mb), 32'(exp_db)}));
    endtask

    // Cancel in cycle cpos after accept (1 = ISSUE); the unit ends in cycle 1+dly.
    task automatic run_cancel(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                              input int dly, input int cpos);
        wait_ready();
        stub_dly = dly;
        op_valid = 1'b1; op_type = t; op_src1 = a; op_src2 = b;
        for (int n = 1; n <= 2 + dly; n++) begin
            @(negedge clk);
            if (n == 1) op_valid = 1'b0;
            op_cancel = (n == cpos);
            if (n == 1 + dly) chk("busy_before_end", 65'(busy), 65'(1));
            if (n == 2 + dly) chk("idle_after_end", 65'({busy, op_ready, res_valid}), 65'(3'b010));
        end
        op_cancel = 1'b0;
    endtask

    initial begin : stim
        logic [1:0]  t;
        logic [31:0] a, b;
        int          mb0, db0, kind, d;
        bit          bad;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", 65'({op_ready, busy, res_valid, res_err, mult_begin, div_begin}), 65'(6'b100000));
        chk("reset_data", 65'({res_hi, res_lo}), 65'(0));
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_operands", 65'({mult_op1, mult_op2}), 65'(0));

        run_op(MULT, 32'h0000_0003, 32'hFFFF_FFFE, 4, 0, 1'b0);
        run_op(DIV, 32'd100, 32'd7, 3, 1, 1'b0);
        run_op(MOD, 32'd100, 32'd7, 5, 0, 1'b0);
        run_op(DIV, 32'h1234_5678, 32'd0, 3, 0, 1'b0);
        run_op(MOD, 32'h0BAD_F00D, 32'd0, 3, 2, 1'b0);
        run_cancel(MULT, 32'd9, 32'd11, 6, 4);
        run_op(MULT, 32'd5, 32'd6, 0, 1, 1'b0);
        run_op(DIV, 32'hFFFF_FFFF, 32'd3, TO, 0, 1'b0);
        run_cancel(DIV, 32'd50, 32'd5, 3, 4);
        run_cancel(MOD, 32'd50, 32'd6, 4, 1);
        run_op(MULT, 32'hDEAD_BEEF, 32'h1000_0001, 2, 1, 1'b1);

        // Illegal op type and cancel-over-accept must both be dropped.
        wait_ready();
        mb0 = mb_cnt;
        db0 = db_cnt;
        op_valid = 1'b1; op_type = 2'b00; op_src1 = $urandom; op_src2 = $urandom;
        @(negedge clk);
        chk("illegal_dropped", 65'({busy, op_ready}), 65'(2'b01));
        op_type = MULT; op_cancel = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; op_cancel = 1'b0;
        chk("cancel_beats_accept", 65'({busy, op_ready}), 65'(2'b01));
        repeat (2) @(negedge clk);
        chk("no_begin_on_drop", 65'({32'(mb_cnt - mb0), 32'(db_cnt - db0)}), 65'(0));

        // Asynchronous reset in the middle of WAIT, then a stray late end strobe.
        stub_dly = 6;
        op_valid = 1'b1; op_type = MULT; op_src1 = 32'h55; op_src2 = 32'h66;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_ctrl", 65'({op_ready, busy, res_valid, res_err, mult_begin, div_begin}), 65'(6'b100000));
        chk("async_reset_data", 65'({res_hi, res_lo, mult_op1}), 65'(0));
        @(negedge clk);
        resetn = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy || res_valid) bad = 1'b1;
        end
        chk("late_end_ignored", 65'(bad), 65'(0));

        for (int i = 0; i < 60; i++) begin
            t = 2'($urandom_range(1, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                if (b == 0) b = 32'd1;
                d = $urandom_range(1, TO);
                run_cancel(t, a, b, d, $urandom_range(1, 1 + d));
            end else begin
                run_op(t, a, b, $urandom_range(0, TO), $urandom_range(0, 3), kind == 1);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 65'(exp_q.size()), 65'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
